// File: rtl/router_register_pkg.sv
// Shared router constants: byte width and the reserved destination address.
package router_register_pkg;
    localparam int         ROUTER_DW    = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_register.sv
// Router datapath stage: header latch, byte path to FIFO, XOR parity check, FSM status flags.
// Latency 1 clk din->dout; on fifo_full the byte parks in ffs_byte and is replayed in LOAD_AFTER_FULL.
module router_register
    import router_register_pkg::*;
#(
    parameter int DW = ROUTER_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pkt_valid,
    input  logic [DW-1:0] din,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          lfd_state,
    input  logic          rst_int_reg,
    output logic          error,
    output logic          parity_done,
    output logic          low_pkt_valid,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] header_byte_q, header_byte_d;
    logic [DW-1:0] ffs_byte_q, ffs_byte_d;
    logic [DW-1:0] int_parity_q, int_parity_d;
    logic [DW-1:0] pkt_parity_q, pkt_parity_d;
    logic          parity_done_q, parity_done_d;
    logic          low_pkt_valid_q, low_pkt_valid_d;
    logic          error_q, error_d;

    // Byte path: header latch, FIFO output byte, and the byte held aside while full
    always_comb begin
        dout_d        = dout_q;
        header_byte_d = header_byte_q;
        ffs_byte_d    = ffs_byte_q;
        if (detect_add && pkt_valid && (din[1:0] != ADDR_INVALID)) begin
            header_byte_d = din;
        end
        if (lfd_state) begin
            dout_d = header_byte_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = din;
        end else if (ld_state && fifo_full) begin
            ffs_byte_d = din;
        end else if (laf_state) begin
            dout_d = ffs_byte_q;
        end
    end

    always_comb begin
        int_parity_d = int_parity_q;
        pkt_parity_d = pkt_parity_q;
        if (detect_add) begin
            int_parity_d = '0;
            pkt_parity_d = '0;
        end else begin
            if (lfd_state && pkt_valid) begin
                int_parity_d = int_parity_q ^ header_byte_q;
            end else if (ld_state && pkt_valid && !full_state) begin
                int_parity_d = int_parity_q ^ din;
            end
            if (ld_state && !pkt_valid && !fifo_full) begin
                pkt_parity_d = din;
            end
        end
    end

    // Status flags; error compares against the parity byte one cycle after it lands
    always_comb begin
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        error_d         = error_q;
        if (detect_add) begin
            parity_done_d = 1'b0;
            error_d       = 1'b0;
        end else begin
            if ((ld_state && !fifo_full && !pkt_valid) ||
                (laf_state && low_pkt_valid_q && !parity_done_q)) begin
                parity_done_d = 1'b1;
            end
            if (parity_done_q) begin
                error_d = (int_parity_q != pkt_parity_q);
            end
        end
        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q        <= '0;
            header_byte_q <= '0;
            ffs_byte_q    <= '0;
        end else begin
            dout_q        <= dout_d;
            header_byte_q <= header_byte_d;
            ffs_byte_q    <= ffs_byte_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_parity_q <= '0;
            pkt_parity_q <= '0;
        end else begin
            int_parity_q <= int_parity_d;
            pkt_parity_q <= pkt_parity_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            error_q         <= error_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign error         = error_q;

endmodule

// File: tb/tb_router_register.sv
// Directed-vector bench for router_register with hand-computed expectations.
module tb_router_register;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [7:0] din;
    logic       fifo_full;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic       rst_int_reg;
    logic       error;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [7:0] dout;

    int total;
    int bad;

    router_register #(.DW(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .din          (din),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .lfd_state    (lfd_state),
        .rst_int_reg  (rst_int_reg),
        .error        (error),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .dout         (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of FSM/source inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic a_da, input logic a_lfd, input logic a_ld, input logic a_laf,
                        input logic a_fs, input logic a_pv, input logic a_ff, input logic a_rir,
                        input logic [7:0] a_din);
        @(negedge clk);
        detect_add  = a_da;
        lfd_state   = a_lfd;
        ld_state    = a_ld;
        laf_state   = a_laf;
        full_state  = a_fs;
        pkt_valid   = a_pv;
        fifo_full   = a_ff;
        rst_int_reg = a_rir;
        din         = a_din;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        {detect_add, lfd_state, ld_state, laf_state, full_state} = '0;
        {pkt_valid, fifo_full, rst_int_reg} = '0;
        din = 8'h00;

        // Reset
        idle();
        chk("rst_dout", dout, 8'h00);
        chk("rst_err", error, 0);
        chk("rst_pd", parity_done, 0);
        chk("rst_low", low_pkt_valid, 0);
        rst = 1'b0;

        // Good packet: 05 ^ 07 ^ 08 = 0A
        step(1, 0, 0, 0, 0, 1, 0, 0, 8'h05);
        step(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("good_hdr", dout, 8'h05);
        step(0, 0, 1, 0, 0, 1, 0, 0, 8'h07);
        chk("good_d0", dout, 8'h07);
        step(0, 0, 1, 0, 0, 1, 0, 0, 8'h08);
        chk("good_d1", dout, 8'h08);
        step(0, 0, 1, 0, 0, 0, 0, 0, 8'h0A);
        chk("good_par", dout, 8'h0A);
        chk("good_pd", parity_done, 1);
        chk("good_low", low_pkt_valid, 1);
        chk("good_err_early", error, 0);
        idle();
        chk("good_err", error, 0);
        chk("good_pd_sticky", parity_done, 1);

        // Bad parity byte 0B
        step(1, 0, 0, 0, 0, 1, 0, 0, 8'h05);
        chk("bad_pd_clr", parity_done, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 1, 0, 0, 8'h07);
        step(0, 0, 1, 0, 0, 1, 0, 0, 8'h08);
        step(0, 0, 1, 0, 0, 0, 0, 0, 8'h0B);
        chk("bad_par", dout, 8'h0B);
        chk("bad_err_early", error, 0);
        idle();
        chk("bad_err", error, 1);

        // rst_int_reg wins over the ld_state & !pkt_valid set
        step(0, 0, 1, 0, 0, 0, 0, 1, 8'h0B);
        chk("rir_low", low_pkt_valid, 0);

        // FIFO full: byte parked then replayed; full_state byte not folded into parity
        step(1, 0, 0, 0, 0, 1, 0, 0, 8'h06);
        chk("ff_err_clr", error, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("ff_hdr", dout, 8'h06);
        step(0, 0, 1, 0, 0, 1, 1, 0, 8'h01);
        chk("ff_hold", dout, 8'h06);
        step(0, 0, 0, 0, 1, 1, 1, 0, 8'h02);
        chk("ff_fs_hold", dout, 8'h06);
        step(0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
        chk("ff_replay", dout, 8'h01);
        chk("ff_laf_pd", parity_done, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 8'h07);
        chk("ff_pd", parity_done, 1);
        idle();
        chk("ff_err", error, 0);

        // Address 3 ignored: previous header 06 reused
        step(1, 0, 0, 0, 0, 1, 0, 0, 8'h07);
        step(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("inv_hdr", dout, 8'h06);
        // Parity byte arrives while full; parity_done set from LOAD_AFTER_FULL
        step(0, 0, 1, 0, 0, 0, 1, 0, 8'h05);
        chk("laf_hold", dout, 8'h06);
        chk("laf_low", low_pkt_valid, 1);
        chk("laf_pd0", parity_done, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        chk("laf_replay", dout, 8'h05);
        chk("laf_pd1", parity_done, 1);

        // Reset mid-packet dominates an active ld_state
        step(1, 0, 0, 0, 0, 1, 0, 0, 8'h05);
        step(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("mid_hdr", dout, 8'h05);
        rst = 1'b1;
        step(0, 0, 1, 0, 0, 1, 0, 0, 8'h07);
        chk("mid_rst_dout", dout, 8'h00);
        chk("mid_rst_low", low_pkt_valid, 0);
        chk("mid_rst_pd", parity_done, 0);
        rst = 1'b0;
        step(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
        chk("mid_hdr_clr", dout, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
